muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
Iterative multiply/divide unit owning the HI/LO register pair for MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI and MTLO.
- Consumes the two register-file read operands (rs, rt) and performs one shift-add or restoring-divide step per clock.
- Exposes HI/LO to the writeback mux for MFHI/MFLO.
- Provides busy so control can stall issue while an operation is in flight.

Parameters:
WIDTH, 32, operand and HI/LO width. Must be even and ≥ 4; iteration count equals WIDTH.
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; not overridden).

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-high reset.
start  in  1  request a new operation. Sampled only when busy=0.
op  in  2  operation: 0=MULT, 1=MULTU, 2=DIV, 3=DIVU. Sampled with start.
a  in  WIDTH  rs operand (multiplicand / dividend).
b  in  WIDTH  rt operand (multiplier / divisor).
mthi  in  1  write wdata to HI (MTHI).
mtlo  in  1  write wdata to LO (MTLO).
wdata  in  WIDTH  MTHI/MTLO data.
busy  out  1  operation in flight.
done  out  1  one-cycle pulse when HI/LO receive a result.
hi  out  WIDTH  HI register.
lo  out  WIDTH  LO register.

Behaviour:
- Clock and reset: clock clk; reset reset, asynchronous, active-high.
  - Reset forces state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0 and clears all datapath registers.
  - Reset mid-operation aborts the operation: no done pulse, HI/LO read 0.
- States:
  - IDLE → RUN on start (edge E0). At E0 latch op, operand magnitudes (two's-complement absolute value for signed ops, raw for unsigned), result sign flags, and counter=WIDTH.
  - RUN: one iteration per edge; counter decrements. On the edge where counter reaches 0 (E32 for WIDTH=32), go to FIX.
  - FIX: at edge E33, apply sign correction, write hi/lo, set done=1, go to IDLE.
- busy = (state != IDLE). It is high from after E0 through E33, so the total latency is WIDTH+1 cycles from start to HI/LO valid.
  - done is registered and high exactly one cycle after E33.
  - A new start is accepted in the same cycle done is high.
- Multiply: unsigned shift-add on magnitudes, giving a 2·WIDTH product.
  - For MULT, the product is negated if sign(a) XOR sign(b).
  - Result: hi = product[2W-1:W], lo = product[W-1:0].
- Divide: restoring division on magnitudes. lo = quotient, hi = remainder.
  - DIV: quotient negated if sign(a) XOR sign(b); remainder takes the sign of the dividend.
  - Signed overflow (−2^(W-1) / −1) gives lo = 0x80000000, hi = 0 (natural result of the magnitude datapath).
- Divide by zero (b=0, DIV or DIVU): no special early exit; full latency. Result is hi = a (unmodified), lo = all ones.
- start while busy: ignored; the in-flight operation is unaffected.
- mthi/mtlo:
  - Applied on the edge only when state=IDLE and start=0.
  - If start=1 in the same cycle, start wins and mthi/mtlo are dropped.
  - When busy, they are ignored.
  - mthi and mtlo together write both registers with wdata.
- hi/lo hold their value during RUN; intermediate partial results never appear on the outputs.
- Operand inputs a and b are only sampled at E0; they may change freely afterward.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU.
  - state encoding: S_IDLE, S_RUN, S_FIX.
  - DIV0_LO constant (all ones).
- The main control decoder imports the op encodings from this package.
- No sub-module: the counter, FSM and the shared adder/subtractor datapath fit in one module. A separate core would only duplicate the operand registers.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF → busy high 33 cycles, done pulse once, hi=0xFFFFFFFE lo=0x00000001.
- MULT a=0xFFFFFFFD (−3) b=7 → hi=0xFFFFFFFF lo=0xFFFFFFEB; then DIV a=0xFFFFFFF9 (−7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 → hi=0x00000064 lo=0xFFFFFFFF after 33 cycles; DIV a=0x80000000 b=0xFFFFFFFF → lo=0x80000000 hi=0.
- Start DIVU 100/7; at cycle 5 assert start (MULTU 2×3) and mthi wdata=0xDEAD → both ignored, final hi=2 lo=14, exactly one done pulse.
- Idle: mthi wdata=0x1234 then mtlo wdata=0x5678 → hi=0x1234 lo=0x5678. Same-cycle start+mtlo → MULTU result wins, lo not 0x5678.
- MULTU in progress, assert reset asynchronously at cycle 10 (mid-clock) → busy=0, hi=lo=0 immediately, no done. Next MULTU 6×7 → lo=42 hi=0.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit and its HI/LO pair.
// Operation codes match the two-bit op field driven by the control decoder.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT  = 2'd0,
        OP_MULTU = 2'd1,
        OP_DIV   = 2'd2,
        OP_DIVU  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_e;

    // Widest supported datapath; users take the low WIDTH bits.
    localparam int MAX_W = 64;

    // Quotient returned on divide by zero.
    localparam logic [MAX_W-1:0] DIV0_LO = '1;

    function automatic logic op_is_signed(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic op_is_div(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning HI/LO: one shift-add or restoring
// divide step per clock, sign correction in a final cycle, MTHI/MTLO writes.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    // Handshake: start is taken on a rising edge only while busy=0 (IDLE);
    // busy stays high until the result edge, and done pulses for the one
    // cycle after it, during which a new start is already accepted.

    state_e state, state_d;

    logic [CNT_W-1:0] cnt;
    logic             is_div_q;
    logic             neg_q;
    logic             neg_r;
    logic             div0_q;
    logic [WIDTH-1:0] dvsr_q;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             done_q;

    logic             load;
    logic             signed_in;
    logic             is_div_in;
    logic [WIDTH-1:0] abs_a;
    logic [WIDTH-1:0] abs_b;

    assign load      = (state == S_IDLE) && start;
    assign signed_in = op_is_signed(op);
    assign is_div_in = op_is_div(op);
    assign abs_a     = (signed_in && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_in && b[WIDTH-1]) ? -b : b;

    // Shared adder: adds the multiplicand for MUL, subtracts the divisor for DIV.
    logic [WIDTH:0]   opnd_x;
    logic [WIDTH:0]   opnd_y;
    logic             cin;
    logic [WIDTH+1:0] sum_full;
    logic             no_borrow;
    logic [WIDTH-1:0] acc_hi_n;
    logic [WIDTH-1:0] acc_lo_n;

    always_comb begin
        opnd_x = '0;
        opnd_y = '0;
        cin    = 1'b0;
        if (is_div_q) begin
            opnd_x = {acc_hi, acc_lo[WIDTH-1]};
            opnd_y = ~{1'b0, dvsr_q};
            cin    = 1'b1;
        end else begin
            opnd_x = {1'b0, acc_hi};
            opnd_y = acc_lo[0] ? {1'b0, dvsr_q} : '0;
        end
    end

    assign sum_full  = {1'b0, opnd_x} + {1'b0, opnd_y} + {{(WIDTH+1){1'b0}}, cin};
    assign no_borrow = sum_full[WIDTH+1];

    always_comb begin
        acc_hi_n = acc_hi;
        acc_lo_n = acc_lo;
        if (is_div_q) begin
            acc_hi_n = no_borrow ? sum_full[WIDTH-1:0] : opnd_x[WIDTH-1:0];
            acc_lo_n = {acc_lo[WIDTH-2:0], no_borrow};
        end else begin
            acc_hi_n = sum_full[WIDTH:1];
            acc_lo_n = {sum_full[0], acc_lo[WIDTH-1:1]};
        end
    end

    // Sign correction applied on the FIX edge.
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    assign prod   = {acc_hi, acc_lo};
    assign prod_s = neg_q ? -prod : prod;
    assign quo    = div0_q ? DIV0_LO[WIDTH-1:0] : (neg_q ? -acc_lo : acc_lo);
    assign rem    = neg_r ? -acc_hi : acc_hi;
    assign fix_hi = is_div_q ? rem : prod_s[2*WIDTH-1:WIDTH];
    assign fix_lo = is_div_q ? quo : prod_s[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (cnt == CNT_W'(1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div0_q   <= 1'b0;
            dvsr_q   <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
        end else if (load) begin
            cnt      <= CNT_W'(WIDTH);
            is_div_q <= is_div_in;
            neg_q    <= signed_in && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r    <= (op == OP_DIV) && a[WIDTH-1];
            div0_q   <= is_div_in && (b == '0);
            dvsr_q   <= is_div_in ? abs_b : abs_a;
            acc_hi   <= '0;
            acc_lo   <= is_div_in ? abs_a : abs_b;
        end else if (state == S_RUN) begin
            cnt      <= cnt - CNT_W'(1);
            acc_hi   <= acc_hi_n;
            acc_lo   <= acc_lo_n;
        end
    end

    // HI/LO only change on the FIX edge or on an idle MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state == S_FIX);
            if (state == S_FIX) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else if ((state == S_IDLE) && !start) begin
                if (mthi) hi_q <= wdata;
                if (mtlo) lo_q <= wdata;
            end
        end
    end

    assign busy = (state != S_IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed and random operations checked through a
// scoreboard of expected {hi, lo} pairs popped on each done pulse.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         mthi;
    logic         mtlo;
    logic [W-1:0] wdata;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks     = 0;
    int failures   = 0;
    int done_count = 0;

    logic [2*W-1:0] exp_q[$];
    logic [W-1:0]   prev_hi;
    logic [W-1:0]   prev_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .mthi  (mthi),
        .mtlo  (mtlo),
        .wdata (wdata),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: {hi, lo} for each operation.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        logic signed [63:0] sq;
        logic signed [63:0] sr;
        logic        [63:0] r;
        sx = {{32{x[W-1]}}, x};
        sy = {{32{y[W-1]}}, y};
        r  = '0;
        case (o)
            2'd0: r = sx * sy;
            2'd1: r = {32'd0, x} * {32'd0, y};
            2'd2: begin
                if (y == '0) begin
                    r = {x, 32'hFFFF_FFFF};
                end else begin
                    sq = sx / sy;
                    sr = sx % sy;
                    r  = {sr[31:0], sq[31:0]};
                end
            end
            default: begin
                if (y == '0) r = {x, 32'hFFFF_FFFF};
                else         r = {x % y, x / y};
            end
        endcase
        return r;
    endfunction

    always @(negedge clk) begin
        if (!reset && done) begin
            logic [63:0] e;
            done_count++;
            check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("res_hi", 64'(hi), 64'(e[63:32]));
                check("res_lo", 64'(lo), 64'(e[31:0]));
            end
        end
    end

    task automatic start_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        prev_hi = hi;
        prev_lo = lo;
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (busy && cyc < 200) begin
            if (cyc == 16) begin
                check("hold_hi", 64'(hi), 64'(prev_hi));
                check("hold_lo", 64'(lo), 64'(prev_lo));
            end
            cyc++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [63:0] e);
        int cyc;
        exp_q.push_back(e);
        start_op(o, x, y);
        wait_done(cyc);
        check("latency", 64'(cyc), 64'd33);
        check("done_pulse", 64'(done), 64'd1);
        @(negedge clk);
        check("done_low", 64'(done), 64'd0);
    endtask

    initial begin
        int cyc;
        int dc0;
        logic [1:0]   ro;
        logic [W-1:0] rx;
        logic [W-1:0] ry;

        reset = 1'b1;
        start = 1'b0;
        op    = 2'd0;
        a     = '0;
        b     = '0;
        mthi  = 1'b0;
        mtlo  = 1'b0;
        wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7,         64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'd3, 32'd100,       32'd0,         64'h0000_0064_FFFF_FFFF);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);

        // Start and MTHI while busy must be ignored.
        dc0 = done_count;
        exp_q.push_back({32'd2, 32'd14});
        start_op(2'd3, 32'd100, 32'd7);
        repeat (4) @(negedge clk);
        start = 1'b1;
        op    = 2'd1;
        a     = 32'd2;
        b     = 32'd3;
        mthi  = 1'b1;
        wdata = 32'h0000_DEAD;
        @(negedge clk);
        start = 1'b0;
        mthi  = 1'b0;
        wait_done(cyc);
        check("ignore_latency", 64'(cyc), 64'd28);
        @(negedge clk);
        check("ignore_one_done", 64'(done_count - dc0), 64'd1);

        mthi  = 1'b1;
        wdata = 32'h0000_1234;
        @(negedge clk);
        mthi  = 1'b0;
        check("mthi_hi", 64'(hi), 64'h1234);
        mtlo  = 1'b1;
        wdata = 32'h0000_5678;
        @(negedge clk);
        mtlo  = 1'b0;
        check("mtlo_lo", 64'(lo), 64'h5678);
        check("mtlo_hi_kept", 64'(hi), 64'h1234);
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h0000_ABCD;
        @(negedge clk);
        mthi  = 1'b0;
        mtlo  = 1'b0;
        check("both_hi", 64'(hi), 64'hABCD);
        check("both_lo", 64'(lo), 64'hABCD);

        // Start in the same cycle as MTLO: the multiply wins.
        mtlo  = 1'b1;
        wdata = 32'h0000_5678;
        run_op(2'd1, 32'd5, 32'd6, {32'd0, 32'd30});

        // Asynchronous reset mid-operation.
        dc0 = done_count;
        start_op(2'd1, 32'h0001_2345, 32'h0000_6789);
        repeat (9) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("abort_no_done", 64'(done_count - dc0), 64'd0);
        run_op(2'd1, 32'd6, 32'd7, {32'd0, 32'd42});

        for (int i = 0; i < 12; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            case ($urandom_range(0, 3))
                0:       ry = '0;
                1:       ry = 32'($urandom_range(1, 15));
                default: ry = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) rx = 32'($urandom_range(0, 255));
            run_op(ro, rx, ry, model(ro, rx, ry));
        end

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
